// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state
// encoding, parity mode codes and small combinational helpers.
package uart_rx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is treated like "none".
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Requested word length, with out-of-range requests mapped to the maximum.
    function automatic logic [3:0] eff_nbits(input logic [3:0] req,
                                             input logic [3:0] max_bits);
        return ((req >= 4'd5) && (req <= max_bits)) ? req : max_bits;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchroniser plus a two-deep tick-sampled history,
// so the majority of the last three tick samples is available on the
// tick that makes a bit decision.
module uart_rx_sampler
    import uart_rx_cfg_pkg::*;
(
    input  logic clk,
    input  logic i_rst,
    input  logic i_rx,
    input  logic i_stick,
    output logic rxs,
    output logic majority
);

    logic       sync_p0;
    logic       sync_p1;
    logic [1:0] hist;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= i_rx;
            sync_p1 <= sync_p0;
        end
    end

    assign rxs = sync_p1;

    // Keep the two previous tick samples; the current one is rxs itself.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            hist <= 2'b11;
        end else if (i_stick) begin
            hist <= {hist[0], rxs};
        end
    end

    assign majority = maj3(hist[1], hist[0], rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..NB_DATA data bits, none/even/odd
// parity, one or two stop bits, with false-start rejection, majority-vote
// bit decisions and parity/framing/break reporting.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_TCOUNT = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_rx,
    input  logic               i_stick,
    input  logic [3:0]         i_nbits,
    input  logic [1:0]         i_parity,
    input  logic               i_stop2,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break,
    output logic               o_busy
);

    localparam logic [NB_TCOUNT-1:0] CNT_MID  = NB_TCOUNT'((2 ** NB_TCOUNT) / 2 - 1);
    localparam logic [NB_TCOUNT-1:0] CNT_LAST = {NB_TCOUNT{1'b1}};
    localparam logic [3:0]           MAX_BITS = 4'(NB_DATA);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [NB_TCOUNT-1:0] tcount;
    logic [3:0]           bit_idx;
    logic [NB_DATA-1:0]   shreg;
    logic [3:0]           nbits_l;
    logic [1:0]           parity_l;
    logic                 stop2_l;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 armed;

    logic                 rxs;
    logic                 majority;

    logic                 sample_mid;
    logic                 decide;
    logic                 start_go;
    logic                 bit_end;
    logic                 data_bit;
    logic                 par_take;
    logic                 stop_next;
    logic                 frame_end;
    logic                 end_ferr;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_rx     (i_rx),
        .i_stick  (i_stick),
        .rxs      (rxs),
        .majority (majority)
    );

    assign sample_mid = i_stick && (tcount == CNT_MID);
    assign decide     = i_stick && (tcount == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and single-cycle datapath strobes.
    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        bit_end    = 1'b0;
        data_bit   = 1'b0;
        par_take   = 1'b0;
        stop_next  = 1'b0;
        frame_end  = 1'b0;
        end_ferr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_stick && !rxs && armed) begin
                    state_next = ST_START;
                    start_go   = 1'b1;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here means the edge was a glitch.
                if (sample_mid) begin
                    state_next = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    bit_end  = 1'b1;
                    data_bit = 1'b1;
                    if (bit_idx == (nbits_l - 4'd1)) begin
                        state_next = parity_on(parity_l) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    bit_end    = 1'b1;
                    par_take   = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    bit_end = 1'b1;
                    if (!majority) begin
                        // A low stop bit ends the frame at once.
                        frame_end  = 1'b1;
                        end_ferr   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (stop2_l && !stop_idx) begin
                        stop_next = 1'b1;
                    end else begin
                        frame_end  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Tick counter: advances on ticks while framing, clears on every transition.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tcount <= '0;
        end else if ((state_next != state) || bit_end) begin
            tcount <= '0;
        end else if (i_stick && (state != ST_IDLE)) begin
            tcount <= tcount + 1'b1;
        end
    end

    // Frame configuration capture and bit assembly.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            nbits_l  <= MAX_BITS;
            parity_l <= PAR_NONE;
            stop2_l  <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            if (start_go) begin
                nbits_l  <= eff_nbits(i_nbits, MAX_BITS);
                parity_l <= i_parity;
                stop2_l  <= i_stop2;
                shreg    <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_bit  <= 1'b0;
            end
            if (data_bit) begin
                for (int i = 0; i < NB_DATA; i++) begin
                    if (bit_idx == 4'(i)) begin
                        shreg[i] <= majority;
                    end
                end
                bit_idx <= bit_idx + 4'd1;
            end
            if (par_take) begin
                par_bit <= majority;
            end
            if (stop_next) begin
                stop_idx <= 1'b1;
            end
        end
    end

    // Start qualification: after a framing error the line must go high again.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            armed <= 1'b0;
        end else if (frame_end && end_ferr) begin
            armed <= 1'b0;
        end else if ((state == ST_IDLE) && rxs) begin
            armed <= 1'b1;
        end
    end

    // Result registers, updated only when a frame completes.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_done    <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_rx_done <= frame_end;
            if (frame_end) begin
                o_data       <= shreg;
                o_parity_err <= parity_on(parity_l) &&
                                ((parity_l == PAR_EVEN) ? (^shreg ^ par_bit)
                                                        : ~(^shreg ^ par_bit));
                o_frame_err  <= end_ferr;
                o_break      <= end_ferr && (shreg == '0) &&
                                !(parity_on(parity_l) && par_bit);
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames from the test plan plus randomized
// frames, checked against a frame-level model held in an expectation queue.
// The baud tick is scaled down (one tick every TICK_DIV clocks) to keep runs short.
module tb_uart_rx_cfg;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk      = 1'b0;
    logic       i_rst    = 1'b1;
    logic       i_rx     = 1'b1;
    logic       i_stick  = 1'b0;
    logic [3:0] i_nbits  = 4'd8;
    logic [1:0] i_parity = 2'b00;
    logic       i_stop2  = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_break;
    logic       o_busy;

    exp_t q[$];
    exp_t cur;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   pushed   = 0;

    uart_rx_cfg #(.NB_DATA(8), .NB_TCOUNT(4)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .i_stick      (i_stick),
        .i_nbits      (i_nbits),
        .i_parity     (i_parity),
        .i_stop2      (i_stop2),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_break      (o_break),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        int tdiv;
        tdiv = 0;
        forever begin
            @(negedge clk);
            i_stick = (tdiv == 0);
            tdiv = (tdiv + 1) % TICK_DIV;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle compare: results must match the model on each done pulse and hold otherwise.
    initial begin
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (i_rst) begin
                cur = '0;
                chk("reset_outputs",
                    32'({o_data, o_rx_done, o_parity_err, o_frame_err, o_break, o_busy}), 32'd0);
            end else if (o_rx_done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = q.pop_front();
                    chk("frame_data", 32'(o_data), 32'(cur.data));
                    chk("frame_flags", 32'({o_parity_err, o_frame_err, o_break}),
                        32'({cur.perr, cur.ferr, cur.brk}));
                end
            end else begin
                chk("hold_outputs", 32'({o_data, o_parity_err, o_frame_err, o_break}),
                    32'({cur.data, cur.perr, cur.ferr, cur.brk}));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic bit_wait();
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 4 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    // Drive one frame and queue the result the receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                              input logic s2, input logic flip, input logic st1,
                              input logic st2, input logic scramble);
        int         neff;
        logic [7:0] dm;
        logic       pen;
        logic       pbit;
        logic       ferr;
        exp_t       e;
        neff = (nb >= 4'd5 && nb <= 4'd8) ? int'(nb) : 8;
        for (int i = 0; i < 8; i++) dm[i] = (i < neff) ? d[i] : 1'b0;
        pen  = (par == 2'b01) || (par == 2'b10);
        pbit = (par == 2'b10) ? ~(^dm) : (^dm);
        if (flip) pbit = ~pbit;
        ferr = !st1 || (s2 && !st2);
        e.data = dm;
        e.perr = pen && ((par == 2'b01) ? ((^dm) ^ pbit) : ~((^dm) ^ pbit));
        e.ferr = ferr;
        e.brk  = ferr && (dm == 8'd0) && !(pen && pbit);
        q.push_back(e);
        pushed++;
        i_nbits  = nb;
        i_parity = par;
        i_stop2  = s2;
        i_rx = 1'b0;
        bit_wait();
        chk("busy_in_frame", 32'(o_busy), 32'd1);
        if (scramble) begin
            i_nbits  = 4'($urandom);
            i_parity = 2'($urandom);
            i_stop2  = 1'($urandom);
        end
        for (int i = 0; i < neff; i++) begin
            i_rx = dm[i];
            bit_wait();
        end
        if (pen) begin
            i_rx = pbit;
            bit_wait();
        end
        i_rx = st1;
        bit_wait();
        if (s2) begin
            i_rx = st2;
            bit_wait();
        end
        i_rx = 1'b1;
        if (ferr) bit_wait();
    endtask

    initial begin
        int base;
        exp_t brk_e;
        repeat (5) @(negedge clk);
        chk("reset_data", 32'(o_data), 32'd0);
        chk("reset_busy_done", 32'({o_busy, o_rx_done}), 32'd0);
        i_rst = 1'b0;
        repeat (2) bit_wait();

        // 8N1 0xA5
        base = done_cnt;
        send_frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("t1_drain");
        chk("t1_data", 32'(o_data), 32'h0A5);
        chk("t1_flags", 32'({o_parity_err, o_frame_err, o_break}), 32'd0);
        chk("t1_done_count", 32'(done_cnt - base), 32'd1);
        chk("t1_idle_busy", 32'(o_busy), 32'd0);

        // 7E1 0x35, wrong then right parity
        send_frame(8'h35, 4'd7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("t2a_drain");
        chk("t2a_data", 32'(o_data), 32'h035);
        chk("t2a_perr", 32'(o_parity_err), 32'd1);
        send_frame(8'h35, 4'd7, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("t2b_drain");
        chk("t2b_perr", 32'(o_parity_err), 32'd0);

        // 8N2 0x3C, bad then good second stop
        send_frame(8'h3C, 4'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drain("t3a_drain");
        chk("t3a_data", 32'(o_data), 32'h03C);
        chk("t3a_flags", 32'({o_parity_err, o_frame_err, o_break}), 32'b010);
        send_frame(8'h3C, 4'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("t3b_drain");
        chk("t3b_flags", 32'({o_parity_err, o_frame_err, o_break}), 32'd0);

        // Glitch shorter than half a bit
        base = done_cnt;
        i_rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        i_rx = 1'b1;
        repeat (2 * TICK_DIV) @(negedge clk);
        chk("t4_busy_on_glitch", 32'(o_busy), 32'd1);
        bit_wait();
        chk("t4_busy_after", 32'(o_busy), 32'd0);
        chk("t4_data_kept", 32'(o_data), 32'h03C);
        chk("t4_no_done", 32'(done_cnt - base), 32'd0);

        // Break: 15 bit times low
        i_nbits = 4'd8; i_parity = 2'b00; i_stop2 = 1'b0;
        base = done_cnt;
        brk_e = '{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
        q.push_back(brk_e);
        pushed++;
        i_rx = 1'b0;
        repeat (15) bit_wait();
        i_rx = 1'b1;
        repeat (2) bit_wait();
        drain("t5_drain");
        chk("t5_done_count", 32'(done_cnt - base), 32'd1);
        chk("t5_data", 32'(o_data), 32'd0);
        chk("t5_flags", 32'({o_parity_err, o_frame_err, o_break}), 32'b011);
        send_frame(8'h5A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("t5b_drain");
        chk("t5b_data", 32'(o_data), 32'h05A);
        chk("t5b_flags", 32'({o_parity_err, o_frame_err, o_break}), 32'd0);

        // Reset part way through 0xFF
        i_nbits = 4'd8; i_parity = 2'b00; i_stop2 = 1'b0;
        i_rx = 1'b0;
        bit_wait();
        i_rx = 1'b1;
        repeat (4) bit_wait();
        chk("t6_busy_before_rst", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_outputs",
            32'({o_data, o_rx_done, o_parity_err, o_frame_err, o_break, o_busy}), 32'd0);
        i_rst = 1'b0;
        bit_wait();
        send_frame(8'h13, 4'd5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("t6_drain");
        chk("t6_data", 32'(o_data), 32'h013);
        chk("t6_flags", 32'({o_parity_err, o_frame_err, o_break}), 32'd0);

        // Randomized frames, mostly back to back, config scrambled mid-frame
        base = done_cnt;
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'd0;
            send_frame(d, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'b1);
            if ($urandom_range(0, 3) == 0) bit_wait();
        end
        drain("rand_drain");
        chk("rand_done_count", 32'(done_cnt - base), 32'd30);
        chk("total_done_count", 32'(done_cnt), 32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
